affine_tap_sched: RTL and testbench

Controller that sequences the 1/16-precision affine interpolation datapath for one sub-block at a time. It accepts a fractional phase per block and streams in 11-bit reference samples row by row. It maintains the sliding tap window feeding the per-tap MCM multiplier blocks and drives the phase select used to pick each tap's Y1..Y15 product. It sits between the reference-sample fetch stage and the tap MCM/adder-tree datapath.

---
 rtl/affine_tap_sched.sv | 155 +++++++++++++++
 tb/tb_affine_tap_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/affine_tap_sched.sv
// affine_tap_sched: sequences the affine interpolation datapath for one sub-block.
// Streams reference samples row by row into a TAPS-deep sliding window and
// presents one window per output pixel, together with the latched phase select.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and a presented window (with its flags)
// holds steady until it is taken.
module affine_tap_sched #(
    parameter int TAPS     = 6,
    parameter int SAMPLE_W = 11,
    parameter int BLK_W    = 4,
    parameter int BLK_H    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    input  logic [3:0]                 cfg_phase,
    output logic                       cfg_ready,
    input  logic                       s_valid,
    input  logic [SAMPLE_W-1:0]        s_data,
    output logic                       s_ready,
    output logic [TAPS*SAMPLE_W-1:0]   win_data,
    output logic                       win_valid,
    input  logic                       m_ready,
    output logic [3:0]                 phase_sel,
    output logic                       bypass,
    output logic                       win_last_col,
    output logic                       win_last,
    output logic                       busy,
    output logic [1:0]                 state_dbg
);

    localparam int FW = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
    localparam int CW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int RW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam logic [FW-1:0] FILL_END = FW'(TAPS - 2);
    localparam logic [CW-1:0] COL_END  = CW'(BLK_W - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(BLK_H - 1);
    localparam int DW = TAPS * SAMPLE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   fill_cnt;
    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic [DW-1:0]   win_q;
    logic            win_valid_q;
    logic            last_col_q;
    logic            last_q;
    logic [3:0]      phase_q;
    logic            bypass_q;

    logic            shift_ok;
    logic            accept;
    logic            start;
    logic            run_accept;
    logic            fill_accept;

    // The window may only shift when nothing is presented or it is being taken.
    assign shift_ok    = !win_valid_q || m_ready;
    assign s_ready     = ((state_q == FILL) || (state_q == RUN)) && shift_ok;
    assign accept      = s_valid && s_ready;
    assign start       = (state_q == IDLE) && cfg_valid;
    assign run_accept  = accept && (state_q == RUN);
    assign fill_accept = accept && (state_q == FILL);

    assign cfg_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign state_dbg    = state_q;
    assign win_data     = win_q;
    assign win_valid    = win_valid_q;
    assign win_last_col = last_col_q;
    assign win_last     = last_q;
    assign phase_sel    = phase_q;
    assign bypass       = bypass_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: rows alternate FILL (prime TAPS-1 samples) and RUN (one window per sample).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (cfg_valid) state_d = FILL;
            FILL:  if (fill_accept && (fill_cnt == FILL_END)) state_d = RUN;
            RUN:   if (run_accept && (col_cnt == COL_END))
                       state_d = (row_cnt == ROW_END) ? DRAIN : FILL;
            DRAIN: if (win_valid_q && m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Block configuration latched once per block; ignored while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= 4'd0;
            bypass_q <= 1'b0;
        end else if (start) begin
            phase_q  <= cfg_phase;
            bypass_q <= (cfg_phase == 4'd0);
        end
    end

    // Fill, column and row counters.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            fill_cnt <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
        end else begin
            if (fill_accept)
                fill_cnt <= (fill_cnt == FILL_END) ? '0 : fill_cnt + FW'(1);
            if (run_accept) begin
                if (col_cnt == COL_END) begin
                    col_cnt <= '0;
                    if (row_cnt != ROW_END) row_cnt <= row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
        end
    end

    // Sliding window: oldest sample leaves tap0, newest enters the top tap.
    always_ff @(posedge clk) begin
        if (rst)         win_q <= '0;
        else if (accept) win_q <= {s_data, win_q[DW-1:SAMPLE_W]};
    end

    // Window presentation: set by a completing sample, cleared when taken without a replacement.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            last_col_q  <= 1'b0;
            last_q      <= 1'b0;
        end else if (run_accept) begin
            win_valid_q <= 1'b1;
            last_col_q  <= (col_cnt == COL_END);
            last_q      <= (col_cnt == COL_END) && (row_cnt == ROW_END);
        end else if (m_ready) begin
            win_valid_q <= 1'b0;
            last_col_q  <= 1'b0;
            last_q      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_affine_tap_sched.sv
// Testbench for affine_tap_sched: directed block runs described by a table of
// {configuration, stimulus pattern, expected phase/bypass} records, plus a
// hand-written reset-mid-block sequence.
module tb_affine_tap_sched;

    localparam int TAPS   = 6;
    localparam int SW     = 11;
    localparam int BW     = 4;
    localparam int BH     = 4;
    localparam int ROW_S  = BW + TAPS - 1;
    localparam int N_SAMP = BH * ROW_S;
    localparam int N_WIN  = BW * BH;
    localparam int DW     = TAPS * SW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic [3:0]    cfg_phase;
    logic          cfg_ready;
    logic          s_valid;
    logic [SW-1:0] s_data;
    logic          s_ready;
    logic [DW-1:0] win_data;
    logic          win_valid;
    logic          m_ready;
    logic [3:0]    phase_sel;
    logic          bypass;
    logic          win_last_col;
    logic          win_last;
    logic          busy;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [SW-1:0] sa[N_SAMP];

    typedef struct {
        logic [3:0] phase;
        int         kind;
        int         stall_at;
        int         stall_len;
        bit         cfg_mid;
        int         abort_at;
        logic [3:0] exp_phase;
        logic       exp_bypass;
    } vec_t;

    vec_t vecs[6];

    // Clock
    always #5 clk = ~clk;

    affine_tap_sched #(
        .TAPS(TAPS), .SAMPLE_W(SW), .BLK_W(BW), .BLK_H(BH)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_phase(cfg_phase), .cfg_ready(cfg_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .win_data(win_data), .win_valid(win_valid), .m_ready(m_ready),
        .phase_sel(phase_sel), .bypass(bypass),
        .win_last_col(win_last_col), .win_last(win_last),
        .busy(busy), .state_dbg(state_dbg)
    );

    task automatic chk_w(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic chk_i(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Sample pattern for a block and the window each output pixel must show.
    task automatic build(input int kind);
        logic [DW-1:0] w;
        int base;
        for (int i = 0; i < N_SAMP; i++) begin
            case (kind)
                0:       sa[i] = SW'(i);
                1:       sa[i] = (i % 3 == 0) ? 11'h400 : ((i % 3 == 1) ? 11'h3ff : SW'(i));
                default: sa[i] = SW'(i * 37 + 5);
            endcase
        end
        exp_q.delete();
        for (int k = 0; k < N_WIN; k++) begin
            base = (k / BW) * ROW_S + (k % BW);
            for (int j = 0; j < TAPS; j++) w[j*SW +: SW] = sa[base + j];
            exp_q.push_back(w);
        end
    endtask

    // Drives one block: cfg, then samples with optional stall / mid-block cfg / abort.
    task automatic run_block(input vec_t v);
        int idx, nwin, cyc, stalled;
        bit mid_done;
        logic [DW-1:0] w;
        build(v.kind);
        idx = 0; nwin = 0; cyc = 0; stalled = 0; mid_done = 0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_phase = v.phase; s_valid = 1'b0; m_ready = 1'b1;
        #1;
        chk_i("cfg_ready_idle", int'(cfg_ready), 1);
        while (nwin < N_WIN && cyc < 400) begin
            @(negedge clk);
            cyc++;
            cfg_valid = 1'b0;
            if (v.cfg_mid && !mid_done && nwin == 5) begin
                cfg_valid = 1'b1; cfg_phase = 4'd3; mid_done = 1'b1;
            end
            s_valid = (idx < N_SAMP);
            s_data  = (idx < N_SAMP) ? sa[idx] : '0;
            m_ready = 1'b1;
            if (v.stall_len > 0 && nwin == v.stall_at && stalled < v.stall_len && win_valid) begin
                m_ready = 1'b0;
                stalled++;
            end
            #1;
            if (cyc == 1) chk_i("busy_fill", int'(busy), 1);
            if (cfg_valid) chk_i("cfg_ready_busy", int'(cfg_ready), 0);
            if (!m_ready) begin
                chk_i("stall_s_ready", int'(s_ready), 0);
                chk_w("stall_hold", win_data, exp_q[0]);
            end
            if (win_valid && m_ready) begin
                w = exp_q.pop_front();
                chk_w("win_data", win_data, w);
                chk_i("win_last_col", int'(win_last_col), int'((nwin % BW) == BW - 1));
                chk_i("win_last", int'(win_last), int'(nwin == N_WIN - 1));
                chk_i("phase_sel", int'(phase_sel), int'(v.exp_phase));
                chk_i("bypass", int'(bypass), int'(v.exp_bypass));
                nwin++;
            end
            if (s_valid && s_ready) idx++;
            if (v.abort_at > 0 && nwin == v.abort_at) return;
        end
        if (nwin < N_WIN) begin
            checks++;
            errors++;
            $display("FAIL block_timeout: got %0d windows required %0d", nwin, N_WIN);
        end
        chk_i("samples_used", idx, N_SAMP);
        chk_i("block_cycles", cyc, N_SAMP + 1 + v.stall_len);
        @(negedge clk);
        s_valid = 1'b0; cfg_valid = 1'b0;
        #1;
        chk_i("cfg_ready_end", int'(cfg_ready), 1);
        chk_i("busy_end", int'(busy), 0);
        chk_i("win_valid_end", int'(win_valid), 0);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_phase = 4'd0;
        s_valid = 1'b1; s_data = '0; m_ready = 1'b1;

        //                phase kind stall_at stall_len mid abort exp_ph byp
        vecs[0] = '{4'd8,  0, 0, 0, 1'b0, 0, 4'd8,  1'b0};
        vecs[1] = '{4'd8,  0, 2, 3, 1'b1, 0, 4'd8,  1'b0};
        vecs[2] = '{4'd3,  2, 0, 0, 1'b0, 0, 4'd3,  1'b0};
        vecs[3] = '{4'd0,  1, 0, 0, 1'b0, 0, 4'd0,  1'b1};
        vecs[4] = '{4'd8,  0, 0, 0, 1'b0, 7, 4'd8,  1'b0};
        vecs[5] = '{4'd15, 0, 0, 0, 1'b0, 0, 4'd15, 1'b0};

        // Reset held two cycles, sample valid asserted to show it is refused.
        repeat (2) @(negedge clk);
        #1;
        chk_i("rst_win_valid", int'(win_valid), 0);
        chk_i("rst_last_col", int'(win_last_col), 0);
        chk_i("rst_last", int'(win_last), 0);
        chk_i("rst_phase_sel", int'(phase_sel), 0);
        chk_i("rst_bypass", int'(bypass), 0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_s_ready", int'(s_ready), 0);
        chk_i("rst_cfg_ready", int'(cfg_ready), 1);
        chk_w("rst_win_data", win_data, '0);
        rst = 1'b0; s_valid = 1'b0;

        for (int t = 0; t < 4; t++) run_block(vecs[t]);

        // Reset after the 7th window, then a fresh block must start cleanly.
        run_block(vecs[4]);
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b1; cfg_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        #1;
        chk_i("midrst_busy", int'(busy), 0);
        chk_i("midrst_win_valid", int'(win_valid), 0);
        chk_i("midrst_cfg_ready", int'(cfg_ready), 1);
        chk_i("midrst_s_ready", int'(s_ready), 0);
        s_valid = 1'b0;
        run_block(vecs[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
